// File: rtl/baby_store_spi.sv
// ============================================================================
// Module   : baby_store_spi
// Purpose  : Register-file main store (DATA_W x 2^ADDR_W) for the Manchester
//            Baby core, with a mode-0 SPI slave that lets an external host
//            load or dump the store while the core is stalled.
// Ports    : clk_i, rst_ni            - system clock, async active-low reset
//            cpu_we_i/addr_i/data_i   - CPU write port (ignored while halted)
//            cpu_data_o               - registered CPU read data
//            cpu_halt_o               - high while an SPI frame owns the store
//            spi_sck_i/cs_ni/pico_i   - SPI inputs (asynchronous to clk_i)
//            spi_poci_o               - SPI read data, MSB first
//            frame_err_o              - one-cycle pulse, CS released mid-word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module baby_store_spi #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_halt_o,
  input  logic              spi_sck_i,
  input  logic              spi_cs_ni,
  input  logic              spi_pico_i,
  output logic              spi_poci_o,
  output logic              frame_err_o
);

  localparam int DEPTH = 1 << ADDR_W;
  // Counts command bits (0..7) and data bits (0..DATA_W-1); DATA_W >= 8.
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  // --------------------------------------------------------------------------
  // Synchronisers and edge detection. CS resets high so that a deasserted pad
  // never produces a false CS-fall when reset is released.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, pico_sync;
  logic                   sck_prev, cs_prev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      pico_sync <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_ni};
      pico_sync <= {pico_sync[SYNC_STAGES-2:0], spi_pico_i};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, pico_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign pico_s   = pico_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign cs_fall  = ~cs_s & cs_prev;

  // --------------------------------------------------------------------------
  // Datapath wires
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]  bit_cnt;
  logic [6:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] shift_q;
  logic              poci_q;

  logic [7:0]        cmd_byte;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] shift_in;
  logic              last_bit;

  // Command byte as it will look once the current SCK-rise bit is taken.
  assign cmd_byte   = {cmd_q, pico_s};
  assign start_addr = cmd_byte[ADDR_W-1:0];
  assign addr_next  = addr_q + ADDR_W'(1);   // natural wrap mod 2^ADDR_W
  assign shift_in   = {shift_q[DATA_W-2:0], pico_s};
  assign last_bit   = (bit_cnt == CNT_W'(DATA_W - 1));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  logic cmd_done, word_done, frame_err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_done    = 1'b0;
    word_done   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) state_d = CMD;
      end
      CMD: begin
        if (cs_rise) begin
          state_d     = IDLE;
          // A select pulse with no clocks at all is not an error.
          frame_err_d = (bit_cnt != '0);
        end else if (sck_rise && bit_cnt == CNT_W'(7)) begin
          cmd_done = 1'b1;
          state_d  = cmd_byte[7] ? WR : RD;
        end
      end
      WR, RD: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt != '0);
        end else if (sck_rise && last_bit) begin
          word_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // SPI shift / count / address registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt     <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      poci_q      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= frame_err_d;
      case (state_q)
        IDLE: begin
          bit_cnt <= '0;
          cmd_q   <= '0;
          poci_q  <= 1'b0;
        end
        CMD: begin
          if (sck_rise && !cs_rise) begin
            cmd_q <= cmd_byte[6:0];
            if (cmd_done) begin
              bit_cnt <= '0;
              addr_q  <= start_addr;
              // Preload for a read; a write simply shifts over it.
              shift_q <= mem[start_addr];
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        WR: begin
          if (sck_rise && !cs_rise) begin
            shift_q <= shift_in;
            if (word_done) begin
              bit_cnt <= '0;
              addr_q  <= addr_next;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        RD: begin
          if (!cs_rise) begin
            // Mode 0: present the next bit on the falling edge.
            if (sck_fall) begin
              poci_q  <= shift_q[DATA_W-1];
              shift_q <= {shift_q[DATA_W-2:0], 1'b0};
            end
            if (sck_rise) begin
              if (word_done) begin
                bit_cnt <= '0;
                addr_q  <= addr_next;
                shift_q <= mem[addr_next];
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Store: SPI owns it while halted, the CPU otherwise.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == WR && word_done) begin
      mem[addr_q] <= shift_in;
    end else if (state_q == IDLE && cpu_we_i) begin
      mem[cpu_addr_i] <= cpu_data_i;
    end
  end

  // Registered read returns pre-write contents on a same-address write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cpu_data_o <= '0;
    else         cpu_data_o <= mem[cpu_addr_i];
  end

  assign cpu_halt_o = (state_q != IDLE);
  assign spi_poci_o = (state_q == RD) & poci_q;

endmodule

`default_nettype wire
